// File: rtl/frame_buffer_pkg.sv
// Definitions shared by the frame-buffer read and write controllers:
// read-FSM state encoding and default geometry / throttle constants.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_READ = 2'd2
    } rd_state_e;

    localparam int FB_ADDR_WIDTH       = 32;
    localparam int FB_FIFO_DEPTH_WIDTH = 9;
    localparam int FB_RD_LATENCY       = 2;
    localparam int FB_THRESHOLD_LOW    = 200;
    localparam int FB_THRESHOLD_HIGH   = 450;

endpackage

// File: rtl/frame_buffer_rd_delay.sv
// LATENCY-stage shift register carrying the read strobe and its start-of-frame
// tag; every stage valid is exposed so the owner can count reads in flight.
module frame_buffer_rd_delay #(
    parameter int LATENCY = 2
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               valid_i,
    input  logic               tag_i,
    output logic [LATENCY-1:0] stage_valid_o,
    output logic               tag_o
);

    logic [LATENCY-1:0] valid_reg;
    logic [LATENCY-1:0] tag_reg;
    logic [LATENCY-1:0] valid_next;
    logic [LATENCY-1:0] tag_next;

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign valid_next[gi] = valid_i;
                assign tag_next[gi]   = tag_i;
            end else begin : g_chain
                assign valid_next[gi] = valid_reg[gi-1];
                assign tag_next[gi]   = tag_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            valid_reg <= '0;
            tag_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            tag_reg   <= tag_next;
        end
    end

    assign stage_valid_o = valid_reg;
    assign tag_o         = tag_reg[LATENCY-1];

endmodule

// File: rtl/control_frame_buffer_read_only.sv
// Read-side frame-buffer controller: sweeps addresses 0..W*H-1 cyclically and
// throttles with hysteresis on the display FIFO level plus reads in flight.
module control_frame_buffer_read_only
    import frame_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH       = FB_ADDR_WIDTH,
    parameter int FIFO_DEPTH_WIDTH = FB_FIFO_DEPTH_WIDTH,
    parameter int RD_LATENCY       = FB_RD_LATENCY,
    parameter int THRESHOLD_LOW    = FB_THRESHOLD_LOW,
    parameter int THRESHOLD_HIGH   = FB_THRESHOLD_HIGH
) (
    input  logic                        clk_i,
    input  logic                        resetn_i,
    input  logic [15:0]                 resolution_width_i,
    input  logic [15:0]                 resolution_depth_i,
    input  logic                        page_written_once_i,
    input  logic                        full_i,
    input  logic [FIFO_DEPTH_WIDTH-1:0] data_count_w_i,
    output logic                        rd_o,
    output logic [ADDR_WIDTH-1:0]       addr_rd_o,
    output logic                        fifo_wr_o,
    output logic                        sof_o,
    output logic                        frame_done_o
);

    localparam int LEVEL_W = FIFO_DEPTH_WIDTH + 2;

    rd_state_e             state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [15:0]           width_reg;
    logic [15:0]           depth_reg;
    logic                  sof_tag_reg;

    logic [ADDR_WIDTH-1:0] in_size;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [RD_LATENCY-1:0] stage_valid;
    logic [LEVEL_W-1:0]    inflight;
    logic [LEVEL_W-1:0]    level;
    logic                  may_start;
    logic                  must_stop;

    assign in_size   = ADDR_WIDTH'(resolution_width_i) * ADDR_WIDTH'(resolution_depth_i);
    assign last_addr = ADDR_WIDTH'(width_reg) * ADDR_WIDTH'(depth_reg) - ADDR_WIDTH'(1);

    // The final delay stage is the FIFO write itself, so it is not counted as in flight.
    always_comb begin
        inflight = LEVEL_W'(rd_o);
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            inflight = inflight + LEVEL_W'(stage_valid[i]);
        end
        level = LEVEL_W'(data_count_w_i) + inflight;
    end

    assign may_start = !full_i && (level <= LEVEL_W'(THRESHOLD_LOW));
    assign must_stop = full_i || (level >= LEVEL_W'(THRESHOLD_HIGH));

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg    <= RD_IDLE;
            ptr_reg      <= '0;
            width_reg    <= '0;
            depth_reg    <= '0;
            rd_o         <= 1'b0;
            addr_rd_o    <= '0;
            sof_tag_reg  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            rd_o         <= 1'b0;
            sof_tag_reg  <= 1'b0;
            frame_done_o <= 1'b0;
            if (!page_written_once_i) begin
                state_reg <= RD_IDLE;
            end else begin
                case (state_reg)
                    RD_IDLE: begin
                        // Geometry tracks the inputs while idle, so it is current on departure.
                        width_reg <= resolution_width_i;
                        depth_reg <= resolution_depth_i;
                        if (in_size != '0) begin
                            state_reg <= RD_WAIT;
                        end
                    end
                    RD_WAIT: begin
                        if (may_start) begin
                            state_reg <= RD_READ;
                        end
                    end
                    RD_READ: begin
                        if (must_stop) begin
                            state_reg <= RD_WAIT;
                        end else begin
                            rd_o         <= 1'b1;
                            addr_rd_o    <= ptr_reg;
                            sof_tag_reg  <= (ptr_reg == '0);
                            frame_done_o <= (ptr_reg == last_addr);
                            if (ptr_reg == last_addr) begin
                                ptr_reg   <= '0;
                                width_reg <= resolution_width_i;
                                depth_reg <= resolution_depth_i;
                            end else begin
                                ptr_reg <= ptr_reg + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    default: state_reg <= RD_IDLE;
                endcase
            end
        end
    end

    frame_buffer_rd_delay #(
        .LATENCY (RD_LATENCY)
    ) u_rd_delay (
        .clk_i         (clk_i),
        .resetn_i      (resetn_i),
        .valid_i       (rd_o),
        .tag_i         (sof_tag_reg),
        .stage_valid_o (stage_valid),
        .tag_o         (sof_o)
    );

    assign fifo_wr_o = stage_valid[RD_LATENCY-1];

endmodule

// File: tb/tb_control_frame_buffer_read_only.sv
// Self-checking bench for the frame-buffer read controller: directed scenarios
// plus randomized throttling against a behavioural reference model.
module tb_control_frame_buffer_read_only;

    localparam int AW    = 32;
    localparam int DW    = 9;
    localparam int LAT   = 2;
    localparam int TLOW  = 200;
    localparam int THIGH = 450;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [15:0]   res_w = '0;
    logic [15:0]   res_h = '0;
    logic          page = 1'b0;
    logic          full = 1'b0;
    logic [DW-1:0] count = '0;
    logic          rd;
    logic [AW-1:0] addr;
    logic          fifo_wr;
    logic          sof;
    logic          frame_done;

    control_frame_buffer_read_only #(
        .ADDR_WIDTH       (AW),
        .FIFO_DEPTH_WIDTH (DW),
        .RD_LATENCY       (LAT),
        .THRESHOLD_LOW    (TLOW),
        .THRESHOLD_HIGH   (THIGH)
    ) dut (
        .clk_i               (clk),
        .resetn_i            (resetn),
        .resolution_width_i  (res_w),
        .resolution_depth_i  (res_h),
        .page_written_once_i (page),
        .full_i              (full),
        .data_count_w_i      (count),
        .rd_o                (rd),
        .addr_rd_o           (addr),
        .fifo_wr_o           (fifo_wr),
        .sof_o               (sof),
        .frame_done_o        (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int next_addr = 0;

    // Reference model: reading mode, pointer, geometry, and the history of
    // issued reads (index 0 = current rd_o, index LAT = read now written to FIFO).
    bit          m_active;
    bit          m_reading;
    logic [31:0] m_ptr;
    logic [31:0] m_w;
    logic [31:0] m_h;
    logic [31:0] m_addr;
    bit          m_fd;
    bit          hist_rd[$];
    bit          hist_tag[$];
    logic [35:0] exp_obs;
    logic [35:0] dut_obs;

    assign dut_obs = {rd, fifo_wr, sof, frame_done, addr};

    task automatic model_reset();
        m_active  = 1'b0;
        m_reading = 1'b0;
        m_ptr     = '0;
        m_w       = '0;
        m_h       = '0;
        m_addr    = '0;
        m_fd      = 1'b0;
        hist_rd   = {};
        hist_tag  = {};
        for (int k = 0; k <= LAT; k++) begin
            hist_rd.push_back(1'b0);
            hist_tag.push_back(1'b0);
        end
        exp_obs = '0;
    endtask

    task automatic model_step();
        int          inflight = 0;
        int          level;
        bit          nrd = 1'b0;
        bit          ntag = 1'b0;
        bit          nfd = 1'b0;
        logic [31:0] last;
        for (int k = 0; k < LAT; k++) inflight += int'(hist_rd[k]);
        level = int'(count) + inflight;
        if (!page) begin
            m_active  = 1'b0;
            m_reading = 1'b0;
        end else if (!m_active) begin
            m_w = 32'(res_w);
            m_h = 32'(res_h);
            m_active = ((m_w * m_h) != 0);
            m_reading = 1'b0;
        end else if (!m_reading) begin
            if (!full && level <= TLOW) m_reading = 1'b1;
        end else if (full || level >= THIGH) begin
            m_reading = 1'b0;
        end else begin
            last   = m_w * m_h - 1;
            nrd    = 1'b1;
            m_addr = m_ptr;
            ntag   = (m_ptr == 0);
            nfd    = (m_ptr == last);
            if (m_ptr == last) begin
                m_ptr = 0;
                m_w   = 32'(res_w);
                m_h   = 32'(res_h);
            end else begin
                m_ptr = m_ptr + 1;
            end
        end
        hist_rd.push_front(nrd);
        hist_tag.push_front(ntag);
        void'(hist_rd.pop_back());
        void'(hist_tag.pop_back());
        m_fd    = nfd;
        exp_obs = {hist_rd[0], hist_rd[LAT], hist_tag[LAT], m_fd, m_addr};
    endtask

    task automatic tick();
        @(posedge clk);
        if (resetn) model_step();
        else model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; page = 1'b0; count = '0; full = 1'b0; res_w = 16'd4; res_h = 16'd2;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_obs !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", dut_obs, 36'd0);
        end
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({rd, fifo_wr, addr} !== 34'd0) begin
                fails++;
                $display("FAIL idle_no_reads cycle %0d: rd=%b fifo_wr=%b addr=%0d expected 0 0 0", i, rd, fifo_wr, addr);
            end
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL idle_model cycle %0d: got %h expected %h", i, dut_obs, exp_obs);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_frame_wrap();
        bit rd_log[$];
        bit sof_log[$];
        int n_reads = 0;
        int run = 0;
        int max_run = 0;
        bit efd;
        page = 1'b1; count = '0; full = 1'b0; res_w = 16'd4; res_h = 16'd2;
        next_addr = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL wrap_model cycle %0d: got %h expected %h", i, dut_obs, exp_obs);
            end
            efd = rd && (next_addr == 7);
            checks++;
            if (frame_done !== efd) begin
                fails++;
                $display("FAIL wrap_frame_done cycle %0d: got %b expected %b", i, frame_done, efd);
            end
            rd_log.push_front(rd);
            sof_log.push_front(rd && (next_addr == 0));
            if (rd) begin
                checks++;
                if (addr !== AW'(next_addr)) begin
                    fails++;
                    $display("FAIL wrap_addr read %0d: got %0d expected %0d", n_reads, addr, next_addr);
                end
                next_addr = (next_addr + 1) % 8;
                n_reads++;
            end
            if (rd_log.size() > LAT) begin
                checks++;
                if (fifo_wr !== rd_log[LAT] || sof !== sof_log[LAT]) begin
                    fails++;
                    $display("FAIL wrap_delay cycle %0d: got wr=%b sof=%b expected wr=%b sof=%b",
                             i, fifo_wr, sof, rd_log[LAT], sof_log[LAT]);
                end
                void'(rd_log.pop_back());
                void'(sof_log.pop_back());
            end
            run = rd ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        checks++;
        if (n_reads < 30) begin
            fails++;
            $display("FAIL wrap_read_count: got %0d expected >= 30", n_reads);
        end
        checks++;
        if (max_run < 30) begin
            fails++;
            $display("FAIL back_to_back: longest run %0d expected >= 30", max_run);
        end
        $display("test_frame_wrap done: %0d reads", n_reads);
    endtask

    task automatic test_hysteresis();
        bit found = 1'b0;
        int waited = 0;
        count = DW'(449);
        tick();
        checks++;
        if (dut_obs !== exp_obs) begin
            fails++;
            $display("FAIL hyst_model: got %h expected %h", dut_obs, exp_obs);
        end
        checks++;
        if (rd !== 1'b0 || addr !== AW'((next_addr + 7) % 8)) begin
            fails++;
            $display("FAIL hyst_stop: got rd=%b addr=%0d expected rd=0 addr=%0d", rd, addr, (next_addr + 7) % 8);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 10) count = DW'(201);
            tick();
            checks++;
            if (rd !== 1'b0 || dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL hyst_hold cycle %0d: got %h expected %h (rd=0)", i, dut_obs, exp_obs);
            end
        end
        count = DW'(TLOW);
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            waited++;
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL hyst_resume_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (rd) begin
                found = 1'b1;
                checks++;
                if (addr !== AW'(next_addr) || waited > 2) begin
                    fails++;
                    $display("FAIL hyst_resume: got addr=%0d after %0d cycles expected addr=%0d within 2", addr, waited, next_addr);
                end
                next_addr = (next_addr + 1) % 8;
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL hyst_resume_timeout: got no read expected read at %0d", next_addr);
        end
        $display("test_hysteresis done");
    endtask

    task automatic test_full_stall();
        bit found = 1'b0;
        count = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL full_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (rd) begin
                checks++;
                if (addr !== AW'(next_addr)) begin
                    fails++;
                    $display("FAIL full_seq: got %0d expected %0d", addr, next_addr);
                end
                next_addr = (next_addr + 1) % 8;
                if (addr == 5) found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL full_reach5_timeout: got no read of 5 expected one");
        end
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (rd !== 1'b0 || addr !== AW'(5) || dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL full_hold cycle %0d: got rd=%b addr=%0d expected rd=0 addr=5", i, rd, addr);
            end
        end
        full = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (rd) begin
                found = 1'b1;
                checks++;
                if (addr !== AW'(6)) begin
                    fails++;
                    $display("FAIL full_resume: got addr=%0d expected 6", addr);
                end
                next_addr = 7;
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL full_resume_timeout: got no read expected read at 6");
        end
        $display("test_full_stall done");
    endtask

    task automatic test_resize();
        int exp_list[12] = '{4, 5, 6, 7, 0, 1, 2, 3, 0, 1, 2, 3};
        bit exp_fd[12]   = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
        bit found = 1'b0;
        int k = 0;
        count = '0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (rd) begin
                checks++;
                if (addr !== AW'(next_addr)) begin
                    fails++;
                    $display("FAIL resize_seq: got %0d expected %0d", addr, next_addr);
                end
                next_addr = (next_addr + 1) % 8;
                if (addr == 3) found = 1'b1;
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL resize_reach3_timeout: got no read of 3 expected one");
        end
        res_w = 16'd2; res_h = 16'd2;
        for (int i = 0; i < 40 && k < 12; i++) begin
            tick();
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL resize_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (rd) begin
                checks++;
                if (addr !== AW'(exp_list[k]) || frame_done !== exp_fd[k]) begin
                    fails++;
                    $display("FAIL resize_addr read %0d: got addr=%0d fd=%b expected addr=%0d fd=%b",
                             k, addr, frame_done, exp_list[k], exp_fd[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 12) begin
            fails++;
            $display("FAIL resize_count: got %0d reads expected 12", k);
        end
        $display("test_resize done");
    endtask

    task automatic test_reset_inflight();
        bit prev = 1'b0;
        bit ready = 1'b0;
        bit found = 1'b0;
        int waited = 0;
        for (int i = 0; i < 20 && !ready; i++) begin
            tick();
            if (rd && prev) ready = 1'b1;
            prev = rd;
        end
        checks++;
        if (!ready) begin
            fails++;
            $display("FAIL rst_inflight_setup: got no back-to-back reads expected two");
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_obs !== 36'd0) begin
            fails++;
            $display("FAIL rst_async_clear: got %h expected %h", dut_obs, 36'd0);
        end
        tick();
        tick();
        checks++;
        if (fifo_wr !== 1'b0 || rd !== 1'b0) begin
            fails++;
            $display("FAIL rst_hold: got wr=%b rd=%b expected 0 0", fifo_wr, rd);
        end
        resetn = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            waited++;
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                $display("FAIL rst_restart_model: got %h expected %h", dut_obs, exp_obs);
            end
            if (rd) begin
                found = 1'b1;
                checks++;
                if (addr !== AW'(0) || waited != 3) begin
                    fails++;
                    $display("FAIL rst_restart: got addr=%0d after %0d cycles expected addr=0 after 3", addr, waited);
                end
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL rst_restart_timeout: got no read expected read of 0");
        end
        $display("test_reset_inflight done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) count = DW'($urandom_range(150, 500));
            full = ($urandom_range(0, 15) == 0);
            page = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 99) == 0) begin
                res_w = 16'($urandom_range(1, 5));
                res_h = 16'($urandom_range(1, 4));
            end
            tick();
            checks++;
            if (dut_obs !== exp_obs) begin
                fails++;
                bad++;
                if (bad <= 10)
                    $display("FAIL rand_model cycle %0d: got %h expected %h (count=%0d full=%b page=%b)",
                             i, dut_obs, exp_obs, count, full, page);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_frame_wrap();
        test_hysteresis();
        test_full_stall();
        test_resize();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
